// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Shares one single-port data memory (32-bit words, 1-cycle synchronous read)
// between the processor MM stage (port C) and the host loader/debug port
// (port H). The grant is decided combinationally each cycle. The winner drives
// the memory address, write data and write enable. Read data comes back one
// cycle after the grant, and the rvalid of the port that won marks it.
//
// Parameters
//   MODE        0 = round-robin, 1 = C-priority with host starvation limit
//   STARVE_MAX  MODE 1: contended cycles H may lose before it is forced to win
//   CNT_W       width of the saturating contention counter
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   c_req/c_we/c_addr/c_wdata port C request, write flag, byte address, data
//   c_gnt                     port C granted this cycle (combinational)
//   c_rvalid                  port C read data valid (cycle after grant)
//   h_*                       same set for port H
//   rdata                     read data shared by both ports (= mem_out)
//   mem_addr/mem_in/mem_we    word address, write data, write enable to memory
//   mem_out                   memory read data (1-cycle latency)
//   conflict_cnt              saturating count of cycles with c_req && h_req
// -----------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int MODE       = 0,
    parameter int STARVE_MAX = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             c_req,
    input  logic             c_we,
    input  logic [31:0]      c_addr,
    input  logic [31:0]      c_wdata,
    output logic             c_gnt,
    output logic             c_rvalid,
    input  logic             h_req,
    input  logic             h_we,
    input  logic [31:0]      h_addr,
    input  logic [31:0]      h_wdata,
    output logic             h_gnt,
    output logic             h_rvalid,
    output logic [31:0]      rdata,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_in,
    output logic             mem_we,
    input  logic [31:0]      mem_out,
    output logic [CNT_W-1:0] conflict_cnt
);

    typedef enum logic {
        LAST_C = 1'b0,
        LAST_H = 1'b1
    } last_t;

    localparam logic [7:0]       STARVE_LIM = 8'(STARVE_MAX);
    localparam logic [CNT_W-1:0] CNT_SAT    = '1;

    last_t            last_grant_reg, last_grant_next;
    logic [7:0]       starve_reg, starve_next;
    logic [CNT_W-1:0] conflict_reg, conflict_next;
    logic             contended;
    logic             c_wins;
    logic [1:0]       gnt_vec;
    logic [1:0]       we_vec;
    logic [1:0]       rvalid_vec;

    assign contended = c_req && h_req;

    // Winner selection. Without contention the sole requester wins. An idle
    // cycle leaves c_wins low, so neither port is granted.
    always_comb begin
        c_wins = c_req;
        if (contended) begin
            if (MODE == 0) begin
                c_wins = (last_grant_reg == LAST_H);
            end else begin
                c_wins = (starve_reg != STARVE_LIM);
            end
        end
    end

    // Grants are masked by rst directly, so no access reaches the memory
    // while reset is held. This also holds in the cycle where reset arrives
    // between edges.
    assign c_gnt = !rst && c_wins;
    assign h_gnt = !rst && h_req && !c_wins;

    // The memory follows H only when H is granted. Otherwise it shows C's
    // request, including in idle cycles.
    assign mem_addr = h_gnt ? {2'b00, h_addr[31:2]} : {2'b00, c_addr[31:2]};
    assign mem_in   = h_gnt ? h_wdata : c_wdata;
    assign mem_we   = (c_gnt && c_we) || (h_gnt && h_we);

    assign rdata        = mem_out;
    assign conflict_cnt = conflict_reg;

    always_comb begin
        last_grant_next = last_grant_reg;
        if (c_gnt) begin
            last_grant_next = LAST_C;
        end else if (h_gnt) begin
            last_grant_next = LAST_H;
        end

        // Counts consecutive cycles in which H waits. Any H grant resets it,
        // and so does any cycle in which H withdraws its request.
        starve_next = 8'd0;
        if ((MODE != 0) && h_req && !h_gnt) begin
            starve_next = (starve_reg == STARVE_LIM) ? starve_reg : starve_reg + 8'd1;
        end

        conflict_next = conflict_reg;
        if (contended && (conflict_reg != CNT_SAT)) begin
            conflict_next = conflict_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_reg <= LAST_H;
            starve_reg     <= 8'd0;
            conflict_reg   <= '0;
        end else begin
            last_grant_reg <= last_grant_next;
            starve_reg     <= starve_next;
            conflict_reg   <= conflict_next;
        end
    end

    // Read-return tags: index 0 = C, index 1 = H. A granted read raises its
    // port's rvalid for exactly the following cycle. Writes raise nothing.
    assign gnt_vec = {h_gnt, c_gnt};
    assign we_vec  = {h_we, c_we};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            logic rvalid_reg;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rvalid_reg <= 1'b0;
                end else begin
                    rvalid_reg <= gnt_vec[gi] && !we_vec[gi];
                end
            end

            assign rvalid_vec[gi] = rvalid_reg;
        end
    endgenerate

    assign c_rvalid = rvalid_vec[0];
    assign h_rvalid = rvalid_vec[1];

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory (32-bit words, 1-cycle synchronous read) between two requesters: port C (processor MM stage) and port H (host loader/debug port).
- Arbitrates each cycle and drives the memory address, write data and write enable from the winner.
- Returns read data one cycle after grant, tagged to the winning port.
- Sits between the processor and the dmem MEM instance.

Parameters:
- MODE, 0, arbitration policy: 0 = round-robin, 1 = C-priority with host starvation limit.
- STARVE_MAX, 4, MODE 1 only: number of consecutive contended cycles H may lose before it is forced to win (range 1..255).
- CNT_W, 16, width of the saturating contention counter.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- c_req  in  1  C access request
- c_we  in  1  C write (1) / read (0)
- c_addr  in  32  C byte address
- c_wdata  in  32  C write data
- c_gnt  out  1  C granted this cycle (combinational)
- c_rvalid  out  1  C read data valid
- h_req, h_we, h_addr, h_wdata, h_gnt, h_rvalid  same as C, for H
- rdata  out  32  read data, shared by both ports
- mem_addr  out  32  word address to memory
- mem_in  out  32  write data to memory
- mem_we  out  1  memory write enable
- mem_out  in  32  memory read data (1-cycle latency)
- conflict_cnt  out  CNT_W  count of cycles with c_req && h_req, saturating

Behaviour:
- Reset (async, while rst=1):
  - c_rvalid = h_rvalid = 0; conflict_cnt = 0; starvation counter = 0.
  - last-grant register = H, so C wins the first contention.
  - c_gnt = h_gnt = 0 and mem_we = 0 while rst is high, forced combinationally.
- Grant (combinational, same cycle):
  - Only one req high: that port is granted.
  - Neither req high: no grant, mem_we = 0, mem_addr/mem_in = C's values.
  - Both req high, MODE 0: the port NOT recorded in last-grant wins.
  - Both req high, MODE 1: C wins unless starvation counter == STARVE_MAX, in which case H wins.
  - At most one gnt is high per cycle.
- Memory drive, from the winner: mem_addr = {2'b0, addr[31:2]}; mem_in = wdata; mem_we = gnt && we. Byte offset addr[1:0] is ignored.
- Last-grant register: updated on every cycle with a grant; holds otherwise.
- Starvation counter (MODE 1):
  - Increments (stops at STARVE_MAX) when h_req && !h_gnt.
  - Clears to 0 when h_gnt is high, or when h_req is low.
- Read return:
  - Registered: c_rvalid <= c_gnt && !c_we; h_rvalid <= h_gnt && !h_we.
  - rdata = mem_out, combinational pass-through. It is meaningful only when an rvalid is high. Exactly one rvalid is high per read, one cycle after its grant.
  - Writes produce no rvalid.
- Handshake:
  - A requester holds req/we/addr/wdata stable until it sees gnt in the same cycle; it may change them the next cycle.
  - A requester may drop req before being granted; nothing is recorded for that access.
  - Back-to-back grants to the same port are allowed every cycle (full throughput, 1 access/cycle).
- conflict_cnt: increments when c_req && h_req, with or without a grant decision change; holds at 2^CNT_W-1 on saturation.
- Simultaneous events:
  - A read grant in cycle N and a write grant in cycle N+1 are both honoured.
  - The rvalid for N appears in N+1 alongside the new grant.
- Reset mid-operation: an outstanding read has its rvalid suppressed (0 in the cycle after rst rises); no partial write is issued after rst asserts.

Test Plan:
- Reset: assert rst mid-cycle asynchronously → c_rvalid, h_rvalid, mem_we and conflict_cnt go to 0 immediately, with no clock edge needed.
- Single read: C reads addr 0x0000_0010 with mem[4] = 0xDEADBEEF → c_gnt = 1 in cycle N, mem_addr = 4, c_rvalid = 1 and rdata = 0xDEADBEEF in N+1, h_rvalid = 0.
- MODE 0 contention: both ports read continuously for 4 cycles → grants alternate C, H, C, H; rvalids alternate one cycle later; conflict_cnt = 4.
- MODE 1 starvation, STARVE_MAX = 3: both ports request continuously → grants are C, C, C, H, C, C, C, H; the starvation counter clears after each H grant.
- Write then read: H writes 0x12345678 to 0x20, then reads 0x20 → mem_we = 1 for one cycle with mem_addr = 8; no rvalid for the write; h_rvalid with rdata = 0x12345678 one cycle after the read grant.
- Saturation and reset mid-read: with CNT_W = 2, 5 contended cycles → conflict_cnt sticks at 3. Then a C read grant followed by rst in the next cycle → c_rvalid = 0.
